// File: rtl/es_pkg.sv
// Shared opcode definitions for the execution stack.
package es_pkg;

  typedef enum logic [2:0] {
    ES_NOP     = 3'd0,
    ES_PUSH    = 3'd1,
    ES_POP     = 3'd2,
    ES_DUP     = 3'd3,
    ES_SWAP    = 3'd4,
    ES_REPL    = 3'd5,
    ES_POPPUSH = 3'd6,
    ES_RSVD    = 3'd7
  } es_op_t;

endpackage

// File: rtl/es_regfile.sv
// DEPTH x WIDTH stack storage: three combinational reads, two write ports.
module es_regfile #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    top_addr,
  input  logic [AW-1:0]    sec_addr,
  input  logic [AW-1:0]    dup_addr,
  output logic [WIDTH-1:0] top_data,
  output logic [WIDTH-1:0] sec_data,
  output logic [WIDTH-1:0] dup_data,
  input  logic             we0,
  input  logic [AW-1:0]    waddr0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             we1,
  input  logic [AW-1:0]    waddr1,
  input  logic [WIDTH-1:0] wdata1
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Entry storage; the second write port is only used by SWAP, never to the same address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (we0) mem[waddr0] <= wdata0;
      if (we1) mem[waddr1] <= wdata1;
    end
  end

  assign top_data = mem[top_addr];
  assign sec_data = mem[sec_addr];
  assign dup_data = mem[dup_addr];

endmodule

// File: rtl/es_stack_unit.sv
// Execution stack: legality decode, occupancy tracking and sticky error flags.
module es_stack_unit
  import es_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int DUP_W = 2,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             es_act,
  input  logic [2:0]       es_op,
  input  logic             pop_amt,
  input  logic [DUP_W-1:0] dup_idx,
  input  logic [WIDTH-1:0] push_val,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             err_ovf,
  output logic             err_unf,
  input  logic             err_clr
);

  localparam int AW = $clog2(DEPTH);

  es_op_t           op;
  logic [CW-1:0]    cnt, cnt_nxt, pop_need;
  logic [AW-1:0]    top_addr, sec_addr, dup_addr, push_addr;
  logic [WIDTH-1:0] top_data, sec_data, dup_data;
  logic             we0, we1;
  logic [AW-1:0]    waddr0, waddr1;
  logic [WIDTH-1:0] wdata0, wdata1;
  logic             room, dup_ok, set_ovf, set_unf;

  // Addresses are only meaningful when the matching legality check passes.
  assign top_addr  = AW'(cnt - CW'(1));
  assign sec_addr  = AW'(cnt - CW'(2));
  assign dup_addr  = AW'(cnt - CW'(1) - CW'(dup_idx));
  assign push_addr = AW'(cnt);
  assign room      = (cnt < CW'(DEPTH));
  assign dup_ok    = (32'(cnt) > 32'(dup_idx));
  assign pop_need  = pop_amt ? CW'(2) : CW'(1);
  assign op        = es_op_t'(es_op);

  es_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .top_addr (top_addr),
    .sec_addr (sec_addr),
    .dup_addr (dup_addr),
    .top_data (top_data),
    .sec_data (sec_data),
    .dup_data (dup_data),
    .we0      (we0),
    .waddr0   (waddr0),
    .wdata0   (wdata0),
    .we1      (we1),
    .waddr1   (waddr1),
    .wdata1   (wdata1)
  );

  // Op decode: refused ops raise a flag and leave array and count untouched.
  always_comb begin
    set_ovf = 1'b0;
    set_unf = 1'b0;
    we0     = 1'b0;
    we1     = 1'b0;
    waddr0  = push_addr;
    wdata0  = push_val;
    waddr1  = sec_addr;
    wdata1  = top_data;
    cnt_nxt = cnt;
    if (es_act) begin
      case (op)
        ES_PUSH: begin
          if (!room) set_ovf = 1'b1;
          else begin
            we0     = 1'b1;
            cnt_nxt = cnt + CW'(1);
          end
        end
        ES_POP: begin
          if (cnt < pop_need) set_unf = 1'b1;
          else cnt_nxt = cnt - pop_need;
        end
        ES_DUP: begin
          set_ovf = !room;
          set_unf = !dup_ok;
          if (room && dup_ok) begin
            we0     = 1'b1;
            wdata0  = dup_data;
            cnt_nxt = cnt + CW'(1);
          end
        end
        ES_SWAP: begin
          if (cnt < CW'(2)) set_unf = 1'b1;
          else begin
            we0    = 1'b1;
            waddr0 = top_addr;
            wdata0 = sec_data;
            we1    = 1'b1;
          end
        end
        ES_REPL: begin
          if (cnt < CW'(2)) set_unf = 1'b1;
          else begin
            we0     = 1'b1;
            waddr0  = sec_addr;
            cnt_nxt = cnt - CW'(1);
          end
        end
        ES_POPPUSH: begin
          if (cnt == '0) set_unf = 1'b1;
          else begin
            we0    = 1'b1;
            waddr0 = top_addr;
          end
        end
        default: ;
      endcase
    end
  end

  // Occupancy and sticky flags; a new error outranks a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      err_ovf <= set_ovf | (err_ovf & ~err_clr);
      err_unf <= set_unf | (err_unf & ~err_clr);
    end
  end

  assign count = cnt;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign out_a = (cnt != '0)     ? top_data : '0;
  assign out_b = (cnt >= CW'(2)) ? sec_data : '0;

endmodule

// File: tb/tb_es_stack_unit.sv
// Scoreboard bench for es_stack_unit with DEPTH=4.
module tb_es_stack_unit;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int DUP_W = 2;
  localparam int CW    = $clog2(DEPTH+1);

  typedef struct {
    string            nm;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [CW-1:0]    c;
    logic             f;
    logic             e;
    logic             ov;
    logic             un;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             es_act = 1'b0;
  logic [2:0]       es_op = 3'd0;
  logic             pop_amt = 1'b0;
  logic [DUP_W-1:0] dup_idx = '0;
  logic [WIDTH-1:0] push_val = '0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] out_a, out_b;
  logic [CW-1:0]    count;
  logic             full, empty, err_ovf, err_unf;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  bit   mon_seen;
  event async_chk;

  es_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DUP_W(DUP_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .es_act   (es_act),
    .es_op    (es_op),
    .pop_amt  (pop_amt),
    .dup_idx  (dup_idx),
    .push_val (push_val),
    .out_a    (out_a),
    .out_b    (out_b),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .err_ovf  (err_ovf),
    .err_unf  (err_unf),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, string fld, logic [WIDTH-1:0] got, logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s %s: got %0h expected %0h", nm, fld, got, exp);
    end
  endfunction

  function automatic void compare(exp_t x);
    chk(x.nm, "out_a",   out_a,   x.a);
    chk(x.nm, "out_b",   out_b,   x.b);
    chk(x.nm, "count",   WIDTH'(count), WIDTH'(x.c));
    chk(x.nm, "full",    WIDTH'(full),    WIDTH'(x.f));
    chk(x.nm, "empty",   WIDTH'(empty),   WIDTH'(x.e));
    chk(x.nm, "err_ovf", WIDTH'(err_ovf), WIDTH'(x.ov));
    chk(x.nm, "err_unf", WIDTH'(err_unf), WIDTH'(x.un));
  endfunction

  // Monitor: after every edge that carried an op or a clear, pop and compare.
  always @(posedge clk) begin
    mon_seen = es_act | err_clr;
    #1;
    if (mon_seen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard: DUT activity with no expected entry");
      end else begin
        compare(exp_q.pop_front());
      end
    end
  end

  // Monitor for reset checks, which happen without a clock edge.
  always @(async_chk) begin
    if (exp_q.size() != 0) compare(exp_q.pop_front());
  end

  task automatic issue(input logic act, input logic [2:0] o, input logic pa,
                       input logic [DUP_W-1:0] di, input logic [WIDTH-1:0] pv, input logic clr);
    @(negedge clk);
    es_act   = act;
    es_op    = o;
    pop_amt  = pa;
    dup_idx  = di;
    push_val = pv;
    err_clr  = clr;
  endtask

  task automatic expect_st(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [CW-1:0] c, input logic f, input logic e,
                           input logic ov, input logic un);
    exp_t x;
    x.nm = nm; x.a = a; x.b = b; x.c = c; x.f = f; x.e = e; x.ov = ov; x.un = un;
    exp_q.push_back(x);
  endtask

  task automatic idle();
    @(negedge clk);
    es_act  = 1'b0;
    err_clr = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    expect_st("reset", 16'h0, 16'h0, 3'd0, 0, 1, 0, 0);
    -> async_chk;
    @(negedge clk);
    reset = 1'b0;

    issue(1, 3'd1, 0, 0, 16'h0011, 0); expect_st("push11",  16'h0011, 16'h0000, 3'd1, 0, 0, 0, 0);
    issue(1, 3'd1, 0, 0, 16'h0022, 0); expect_st("push22",  16'h0022, 16'h0011, 3'd2, 0, 0, 0, 0);
    issue(1, 3'd4, 0, 0, 16'h0000, 0); expect_st("swap",    16'h0011, 16'h0022, 3'd2, 0, 0, 0, 0);
    issue(1, 3'd5, 0, 0, 16'h0033, 0); expect_st("repl",    16'h0033, 16'h0000, 3'd1, 0, 0, 0, 0);
    issue(1, 3'd2, 0, 0, 16'h0000, 0); expect_st("pop1",    16'h0000, 16'h0000, 3'd0, 0, 1, 0, 0);

    issue(1, 3'd1, 0, 0, 16'd1, 0); expect_st("fill1", 16'd1, 16'd0, 3'd1, 0, 0, 0, 0);
    issue(1, 3'd1, 0, 0, 16'd2, 0); expect_st("fill2", 16'd2, 16'd1, 3'd2, 0, 0, 0, 0);
    issue(1, 3'd1, 0, 0, 16'd3, 0); expect_st("fill3", 16'd3, 16'd2, 3'd3, 0, 0, 0, 0);
    issue(1, 3'd1, 0, 0, 16'd4, 0); expect_st("fill4", 16'd4, 16'd3, 3'd4, 1, 0, 0, 0);
    issue(1, 3'd1, 0, 0, 16'd5, 0); expect_st("ovf5",  16'd4, 16'd3, 3'd4, 1, 0, 1, 0);
    issue(1, 3'd2, 1, 0, 16'd0, 0); expect_st("pop2",  16'd2, 16'd1, 3'd2, 0, 0, 1, 0);
    issue(0, 3'd0, 0, 0, 16'd0, 1); expect_st("clrovf", 16'd2, 16'd1, 3'd2, 0, 0, 0, 0);
    issue(1, 3'd2, 1, 0, 16'd0, 0); expect_st("pop2b", 16'd0, 16'd0, 3'd0, 0, 1, 0, 0);

    issue(1, 3'd2, 0, 0, 16'd0, 0); expect_st("e_pop",   16'd0, 16'd0, 3'd0, 0, 1, 0, 1);
    issue(1, 3'd4, 0, 0, 16'd0, 0); expect_st("e_swap",  16'd0, 16'd0, 3'd0, 0, 1, 0, 1);
    issue(1, 3'd3, 0, 0, 16'd0, 0); expect_st("e_dup",   16'd0, 16'd0, 3'd0, 0, 1, 0, 1);
    issue(1, 3'd2, 0, 0, 16'd0, 1); expect_st("clr_set", 16'd0, 16'd0, 3'd0, 0, 1, 0, 1);
    issue(0, 3'd0, 0, 0, 16'd0, 1); expect_st("clr",     16'd0, 16'd0, 3'd0, 0, 1, 0, 0);
    issue(1, 3'd6, 0, 0, 16'h9, 0); expect_st("e_ppush", 16'd0, 16'd0, 3'd0, 0, 1, 0, 1);
    issue(0, 3'd0, 0, 0, 16'd0, 1); expect_st("clr2",    16'd0, 16'd0, 3'd0, 0, 1, 0, 0);

    issue(1, 3'd1, 0, 0, 16'h000A, 0); expect_st("pushA", 16'h000A, 16'h0000, 3'd1, 0, 0, 0, 0);
    issue(1, 3'd1, 0, 0, 16'h000B, 0); expect_st("pushB", 16'h000B, 16'h000A, 3'd2, 0, 0, 0, 0);
    issue(1, 3'd1, 0, 0, 16'h000C, 0); expect_st("pushC", 16'h000C, 16'h000B, 3'd3, 0, 0, 0, 0);
    issue(1, 3'd3, 0, 2'd3, 16'h0, 0); expect_st("dup3_unf", 16'h000C, 16'h000B, 3'd3, 0, 0, 0, 1);
    issue(0, 3'd0, 0, 0, 16'h0, 1);    expect_st("clr3",     16'h000C, 16'h000B, 3'd3, 0, 0, 0, 0);
    issue(1, 3'd3, 0, 2'd2, 16'h0, 0); expect_st("dup2",     16'h000A, 16'h000C, 3'd4, 1, 0, 0, 0);
    issue(1, 3'd3, 0, 2'd0, 16'h0, 0); expect_st("dup_full", 16'h000A, 16'h000C, 3'd4, 1, 0, 1, 0);
    issue(1, 3'd6, 0, 0, 16'h0055, 0); expect_st("poppush",  16'h0055, 16'h000C, 3'd4, 1, 0, 1, 0);
    issue(1, 3'd2, 0, 0, 16'h0, 0);    expect_st("pop_to3",  16'h000C, 16'h000B, 3'd3, 0, 0, 1, 0);
    idle();

    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    expect_st("async_rst", 16'h0, 16'h0, 3'd0, 0, 1, 0, 0);
    -> async_chk;
    @(negedge clk);
    reset = 1'b0;

    issue(1, 3'd1, 0, 0, 16'h0077, 0); expect_st("push77", 16'h0077, 16'h0000, 3'd1, 0, 0, 0, 0);
    issue(1, 3'd7, 0, 0, 16'h0099, 0); expect_st("rsvd",   16'h0077, 16'h0000, 3'd1, 0, 0, 0, 0);
    issue(1, 3'd5, 0, 0, 16'h0088, 0); expect_st("e_repl", 16'h0077, 16'h0000, 3'd1, 0, 0, 0, 1);
    idle();

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
